serpent_req_arbiter: RTL and testbench

Shares one Serpent core among NUM_REQ requesters. Each requester presents a direction, key and block. The arbiter grants requests round-robin, drives the core's new_block/ready handshake and holds the core inputs stable. It returns the result, tagged with the requester id, on one shared response channel. A watchdog covers a core that never completes. Sits between the system request fabric and the single Serpent encrypt/decrypt instance.

---
 rtl/serpent_req_arbiter.sv | 175 +++++++++++++++++
 tb/tb_serpent_req_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serpent_req_arbiter.sv
// serpent_req_arbiter: round-robin front end that shares one Serpent core
// among NUM_REQ requesters. It launches one block at a time, holds the core
// inputs steady while the core works, and returns the result tagged with the
// requester id. A watchdog ends a WAIT that never sees the core complete.
module serpent_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic [NUM_REQ-1:0]     i_req_dir,
  input  logic [256*NUM_REQ-1:0] i_req_key,
  input  logic [128*NUM_REQ-1:0] i_req_data,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic [127:0]           o_rsp_data,
  output logic                   o_rsp_timeout,
  output logic                   o_core_dir,
  output logic [255:0]           o_core_key,
  output logic [127:0]           o_core_data,
  output logic                   o_core_new_block,
  input  logic                   i_core_ready,
  input  logic [127:0]           i_core_output,
  output logic                   o_busy
);

  // Wait counter only needs to reach TIMEOUT; it saturates at all-ones.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_dir_q, core_dir_d;
  logic [255:0]      core_key_q, core_key_d;
  logic [127:0]      core_data_q, core_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [127:0]      rsp_data_q, rsp_data_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              rise;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;

  logic [255:0]      key_slice  [NUM_REQ];
  logic [127:0]      data_slice [NUM_REQ];

  // Unpack the flat per-requester buses into indexable arrays.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign key_slice[gi]  = i_req_key[256*gi +: 256];
    assign data_slice[gi] = i_req_data[128*gi +: 128];
  end

  // Round-robin winner: first valid at or above ptr, else first valid from 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!grant_found && i_req_valid[r] && (ID_W'(r) >= ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(r);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!grant_found && i_req_valid[r]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(r);
      end
    end
  end

  // One-hot accept, only offered while idle.
  always_comb begin
    o_req_ready = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      o_req_ready[r] = (state_q == IDLE) && grant_found && (grant_idx == ID_W'(r));
    end
  end

  assign rise        = i_core_ready & ~rdy_q;
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  // Next-state and datapath updates; everything defaults to hold.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    rdy_d         = i_core_ready;
    cnt_d         = cnt_q;
    core_dir_d    = core_dir_q;
    core_key_d    = core_key_q;
    core_data_d   = core_data_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          core_dir_d  = i_req_dir[grant_idx];
          core_key_d  = key_slice[grant_idx];
          core_data_d = data_slice[grant_idx];
          rsp_id_d    = grant_idx;
          ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (rise) begin
          rsp_data_d    = i_core_output;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (timeout_hit) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any block in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      rdy_q         <= 1'b0;
      cnt_q         <= '0;
      core_dir_q    <= 1'b0;
      core_key_q    <= '0;
      core_data_q   <= '0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      rdy_q         <= rdy_d;
      cnt_q         <= cnt_d;
      core_dir_q    <= core_dir_d;
      core_key_q    <= core_key_d;
      core_data_q   <= core_data_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign o_core_new_block = (state_q == LAUNCH);
  assign o_rsp_valid      = (state_q == RESP);
  assign o_busy           = (state_q != IDLE);
  assign o_rsp_id         = rsp_id_q;
  assign o_rsp_data       = rsp_data_q;
  assign o_rsp_timeout    = rsp_timeout_q;
  assign o_core_dir       = core_dir_q;
  assign o_core_key       = core_key_q;
  assign o_core_data      = core_data_q;

endmodule

// File: tb/tb_serpent_req_arbiter.sv
// Testbench for serpent_req_arbiter: three requesters, TIMEOUT=16, and a stub
// core whose output is a fixed keyed scramble of its inputs and whose ready
// timing is chosen per transaction (normal completion, hang, stuck high).
module tb_serpent_req_arbiter;
  localparam int N    = 3;
  localparam int TOUT = 16;

  logic           i_clk = 1'b0;
  logic           i_reset;
  logic [N-1:0]   i_req_valid;
  logic [N-1:0]   o_req_ready;
  logic [N-1:0]   i_req_dir;
  logic [256*N-1:0] i_req_key;
  logic [128*N-1:0] i_req_data;
  logic           o_rsp_valid;
  logic           i_rsp_ready;
  logic [1:0]     o_rsp_id;
  logic [127:0]   o_rsp_data;
  logic           o_rsp_timeout;
  logic           o_core_dir;
  logic [255:0]   o_core_key;
  logic [127:0]   o_core_data;
  logic           o_core_new_block;
  logic           i_core_ready;
  logic [127:0]   i_core_output;
  logic           o_busy;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int txn_no = 0;

  logic [255:0] key_m  [N];
  logic [127:0] data_m [N];
  logic         dir_m  [N];

  serpent_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_dir(i_req_dir), .i_req_key(i_req_key), .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data), .o_rsp_timeout(o_rsp_timeout),
    .o_core_dir(o_core_dir), .o_core_key(o_core_key), .o_core_data(o_core_data),
    .o_core_new_block(o_core_new_block), .i_core_ready(i_core_ready),
    .i_core_output(i_core_output), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Stub core transform; invertible per direction, distinct for every input.
  function automatic logic [127:0] core_fn(input logic d, input logic [255:0] k,
                                           input logic [127:0] x);
    logic [127:0] y;
    y = x ^ k[127:0] ^ {k[191:128], k[255:192]};
    return d ? ~y : y;
  endfunction

  assign i_core_output = core_fn(o_core_dir, o_core_key, o_core_data);

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Round-robin reference: scan from the model pointer with modular arithmetic.
  function automatic int pick(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[(ptr_m + i) % N]) return (ptr_m + i) % N;
    end
    return -1;
  endfunction

  // mode 0: core completes after lat WAIT cycles; 1: core hangs low; 2: ready stuck high.
  task automatic run_txn(input logic [N-1:0] mask, input int mode, input int lat, input int hold);
    int g, exp_cyc;
    logic [127:0] exp_data;
    logic exp_to;
    for (int r = 0; r < N; r++) begin
      dir_m[r] = 1'($urandom);
      for (int w = 0; w < 8; w++) key_m[r][32*w +: 32] = $urandom;
      for (int w = 0; w < 4; w++) data_m[r][32*w +: 32] = $urandom;
      i_req_dir[r] = dir_m[r];
      i_req_key[256*r +: 256] = key_m[r];
      i_req_data[128*r +: 128] = data_m[r];
    end
    i_core_ready = (mode == 2);
    i_rsp_ready  = 1'b0;
    i_req_valid  = mask;
    g        = pick(mask);
    ptr_m    = (g + 1) % N;
    exp_to   = (mode != 0);
    exp_data = exp_to ? 128'd0 : core_fn(dir_m[g], key_m[g], data_m[g]);
    exp_cyc  = exp_to ? TOUT + 1 : lat + 1;
    txn_no++;
    $display("txn %0d mask=%b grant=%0d mode=%0d lat=%0d hold=%0d", txn_no, mask, g, mode, lat, hold);
    #1;
    chk("grant", 256'(o_req_ready), 256'(3'b001 << g));
    chk("idle_busy", 256'(o_busy), 256'd0);
    @(negedge i_clk);
    i_req_valid[g] = 1'b0;
    i_req_data[128*g +: 128] = ~data_m[g];
    #1;
    chk("launch_nb", 256'(o_core_new_block), 256'd1);
    chk("launch_dir", 256'(o_core_dir), 256'(dir_m[g]));
    chk("launch_key", o_core_key, key_m[g]);
    chk("launch_data", 256'(o_core_data), 256'(data_m[g]));
    chk("launch_ready", 256'(o_req_ready), 256'd0);
    for (int j = 1; j <= exp_cyc; j++) begin
      @(negedge i_clk);
      if (j < exp_cyc) begin
        chk("wait_valid", 256'(o_rsp_valid), 256'd0);
        chk("wait_nb", 256'(o_core_new_block), 256'd0);
        chk("wait_key", o_core_key, key_m[g]);
        chk("wait_ready", 256'(o_req_ready), 256'd0);
      end
      if (mode == 0 && j == lat) i_core_ready = 1'b1;
    end
    chk("rsp_valid", 256'(o_rsp_valid), 256'd1);
    chk("rsp_id", 256'(o_rsp_id), 256'(g));
    chk("rsp_data", 256'(o_rsp_data), 256'(exp_data));
    chk("rsp_timeout", 256'(o_rsp_timeout), 256'(exp_to));
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      chk("hold_valid", 256'(o_rsp_valid), 256'd1);
      chk("hold_data", 256'(o_rsp_data), 256'(exp_data));
      chk("hold_id", 256'(o_rsp_id), 256'(g));
      chk("hold_nb", 256'(o_core_new_block), 256'd0);
      chk("hold_ready", 256'(o_req_ready), 256'd0);
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    chk("accept_valid", 256'(o_rsp_valid), 256'd0);
    chk("accept_busy", 256'(o_busy), 256'd0);
    i_rsp_ready  = 1'b0;
    i_core_ready = 1'b0;
    i_req_valid  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_req_valid = '0; i_req_dir = '0; i_req_key = '0; i_req_data = '0;
    i_rsp_ready = 1'b0; i_core_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_ready", 256'(o_req_ready), 256'd0);
    chk("rst_valid", 256'(o_rsp_valid), 256'd0);
    chk("rst_busy", 256'(o_busy), 256'd0);
    chk("rst_nb", 256'(o_core_new_block), 256'd0);
    chk("rst_key", o_core_key, 256'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Contention from ptr 0, then requester 2 to bring ptr back to 0.
    run_txn(3'b011, 0, 3, 0);
    run_txn(3'b011, 0, 1, 0);
    run_txn(3'b100, 0, 5, 1);
    // Wrap and fairness: all valid for six blocks.
    for (int k = 0; k < 6; k++) run_txn(3'b111, 0, 2 + k, 0);
    // Timeout with 20 cycles of back-pressure, stuck-high ready, rise on the timeout cycle.
    run_txn(3'b001, 1, 0, 20);
    run_txn(3'b010, 2, 0, 0);
    run_txn(3'b100, 0, TOUT, 0);
    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      int m;
      m = int'($urandom_range(0, 9));
      run_txn(3'($urandom_range(1, 7)), (m == 0) ? 1 : (m == 1) ? 2 : 0,
              int'($urandom_range(1, TOUT)), int'($urandom_range(0, 4)));
    end

    // Reset during WAIT; a later core rise must not produce a response.
    i_req_valid = 3'b010;
    @(negedge i_clk);
    i_req_valid = '0;
    repeat (3) @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    chk("arst_busy", 256'(o_busy), 256'd0);
    chk("arst_valid", 256'(o_rsp_valid), 256'd0);
    chk("arst_key", o_core_key, 256'd0);
    chk("arst_data", 256'(o_core_data), 256'd0);
    chk("arst_id", 256'(o_rsp_id), 256'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    ptr_m = 0;
    repeat (2) @(negedge i_clk);
    i_core_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      chk("post_rst_valid", 256'(o_rsp_valid), 256'd0);
      chk("post_rst_busy", 256'(o_busy), 256'd0);
    end
    i_core_ready = 1'b0;
    @(negedge i_clk);
    run_txn(3'b111, 0, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
